// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states, data widths and the fetch FIFO entry.
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are always word aligned
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with a combinational head and flush.
module fetch_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // A flush swallows any same-cycle push or pop
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Storage; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); occupancy tracks push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory requests, buffers responses in a
// prefetch FIFO and discards in-flight responses after a redirect.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);

    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int QPTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SUM_W  = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [OUT_W-1:0] discard_q, discard_d;
    logic             en_q;

    logic [XLEN-1:0]   pcq_q [MAX_OUT];
    logic [QPTR_W-1:0] pcq_wr_q;
    logic [QPTR_W-1:0] pcq_rd_q;

    logic             grant;
    logic             rsp;
    logic             push;
    logic [CNT_W-1:0] fifo_count;
    logic [SUM_W-1:0] inflight;
    fetch_entry_t     head;
    fetch_entry_t     push_data;

    function automatic logic [QPTR_W-1:0] qinc(input logic [QPTR_W-1:0] p);
        return (p == QPTR_W'(MAX_OUT - 1)) ? '0 : p + QPTR_W'(1);
    endfunction

    // A response with nothing in flight is ignored and never counted
    assign grant    = imem_req && imem_gnt;
    assign rsp      = imem_rvalid && (outst_q != '0);
    assign outst_d  = outst_q + OUT_W'(grant) - OUT_W'(rsp);
    assign inflight = SUM_W'(fifo_count) + SUM_W'(outst_q);

    // FSM state, redirect discard count and fetch PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            discard_q  <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            discard_q  <= discard_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Next state: redirect restarts fetch and counts stale responses to drop
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;
        if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? DRAIN : RUN;
        end else if ((state_q == DRAIN) && rsp) begin
            discard_d = discard_q - OUT_W'(1);
            if (discard_q == OUT_W'(1)) state_d = RUN;
        end
    end

    // Outputs: request only with room for the response; buffer only live responses
    always_comb begin
        imem_req = 1'b0;
        push     = 1'b0;
        if ((state_q == RUN) && en_q && !redirect_valid) begin
            imem_req = (inflight < SUM_W'(DEPTH)) && (outst_q < OUT_W'(MAX_OUT));
        end
        push = (state_q == RUN) && rsp && !redirect_valid;
    end

    // In-flight bookkeeping: outstanding count, issue-PC ring, post-reset enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            outst_q  <= '0;
            pcq_wr_q <= '0;
            pcq_rd_q <= '0;
            for (int i = 0; i < MAX_OUT; i++) pcq_q[i] <= '0;
        end else begin
            en_q    <= 1'b1;
            outst_q <= outst_d;
            if (grant) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q        <= qinc(pcq_wr_q);
            end
            if (rsp) pcq_rd_q <= qinc(pcq_rd_q);
        end
    end

    assign imem_addr = fetch_pc_q;
    assign push_data = '{pc: pcq_q[pcq_rd_q], inst: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (out_ready),
        .flush_i    (redirect_valid),
        .head_o     (head),
        .count_o    (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;

`ifndef SYNTHESIS
    a_rvalid_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outst_q != '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + random bench for fetch_unit against an in-order memory and stream model.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    fetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0, cyc_no = 0;
    // memory model: in-order queue of granted addresses with earliest response cycle
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    // stream model: next expected request address and next expected delivered pc
    logic [31:0] exp_addr, exp_opc;
    int          stale, bufc;
    logic        gnt_v = 1'b0, ready_v = 1'b0, mem_en = 1'b1;
    logic        pend_redir = 1'b0;
    logic [31:0] pend_tgt = '0;
    logic        p_req, p_gnt, p_ov, p_rdy, p_redir;
    logic [31:0] p_addr, p_opc, p_inst;
    int          n_grant, n_pop, first_gnt, first_ov;
    logic        arm_first = 1'b0;
    logic [31:0] first_pc = 32'hFFFF_FFFF;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, update the model
    task automatic cyc();
        logic        rv, req, ov, legal;
        logic [31:0] ra, addr, opc, oinst;
        @(negedge clk);
        cyc_no++;
        rv = mem_en && (mq_addr.size() > 0) && (mq_due[0] <= cyc_no);
        ra = rv ? mq_addr[0] : 32'h0;
        imem_gnt       = gnt_v;
        imem_rvalid    = rv;
        imem_rdata     = rv ? inst_of(ra) : $urandom;
        redirect_valid = pend_redir;
        redirect_pc    = pend_tgt;
        out_ready      = ready_v;
        #1;
        req = imem_req; addr = imem_addr; ov = out_valid; opc = out_pc; oinst = out_inst;

        if (p_req && !p_gnt) chk("addr_hold", addr, p_addr);
        if (p_redir) chk("flush_ov", ov, 1'b0);
        else if (p_ov && !p_rdy) begin
            chk("hold_ov", ov, 1'b1);
            chk("hold_pc", opc, p_opc);
            chk("hold_inst", oinst, p_inst);
        end
        chk("ov_vs_model", ov, bufc != 0);
        legal = (stale == 0) && (mq_addr.size() < MAX_OUT) && (mq_addr.size() + bufc < DEPTH);
        if (req) chk("req_legal", legal, 1'b1);
        if (ov && first_ov < 0) first_ov = cyc_no;

        if (ov && ready_v) begin
            chk("out_pc", opc, exp_opc);
            chk("out_inst", oinst, inst_of(exp_opc));
            if (arm_first) begin first_pc = opc; arm_first = 1'b0; end
            exp_opc += 32'd4;
            n_pop++;
            if (bufc > 0) bufc--;
        end
        if (rv) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            if (stale > 0) stale--;
            else if (!pend_redir) bufc++;
        end
        if (req && gnt_v) begin
            chk("gnt_addr", addr, exp_addr);
            exp_addr += 32'd4;
            mq_addr.push_back(addr);
            mq_due.push_back(cyc_no + 1);
            n_grant++;
            if (first_gnt < 0) first_gnt = cyc_no;
        end
        if (pend_redir) begin
            chk("req_in_redir", req, 1'b0);
            exp_addr  = {pend_tgt[31:2], 2'b00};
            exp_opc   = exp_addr;
            bufc      = 0;
            stale     = mq_addr.size();
            arm_first = 1'b1;
            first_pc  = 32'hFFFF_FFFF;
        end

        p_req = req; p_gnt = gnt_v; p_addr = addr; p_ov = ov; p_rdy = ready_v;
        p_opc = opc; p_inst = oinst; p_redir = pend_redir;
        pend_redir = 1'b0;
    endtask

    // Asynchronous reset mid-cycle; memory forgets pre-reset requests
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        mq_addr.delete(); mq_due.delete();
        exp_addr = RESET_PC; exp_opc = RESET_PC; stale = 0; bufc = 0;
        p_req = 0; p_gnt = 0; p_ov = 0; p_rdy = 0; p_redir = 0;
        p_addr = '0; p_opc = '0; p_inst = '0;
        pend_redir = 1'b0; arm_first = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_grant = 0; n_pop = 0; first_gnt = -1; first_ov = -1;
    endtask

    initial begin
        logic [31:0] a0;

        // streaming with a 1-cycle memory
        do_reset();
        gnt_v = 1; ready_v = 1; mem_en = 1;
        repeat (14) cyc();
        chk("s1_latency", first_ov - first_gnt, 2);
        chk("s1_pops", n_pop, 14 - (first_gnt + 2) + 1);

        // decode stalled: FIFO fills, requests stop, head held at pc 0
        do_reset();
        gnt_v = 1; ready_v = 0;
        repeat (10) cyc();
        chk("s2_grants", n_grant, DEPTH);
        chk("s2_req", imem_req, 1'b0);
        chk("s2_ov", out_valid, 1'b1);
        chk("s2_pc", out_pc, RESET_PC);
        chk("s2_inst", out_inst, inst_of(RESET_PC));

        // grant withheld for 3 cycles while requesting
        ready_v = 1;
        repeat (4) cyc();
        gnt_v = 0;
        repeat (2) cyc();
        a0 = imem_addr;
        cyc();
        chk("s3_req_high", imem_req, 1'b1);
        chk("s3_addr_stable", imem_addr, a0);
        chk("s3_addr_model", imem_addr, exp_addr);
        gnt_v = 1;
        repeat (10) cyc();

        // redirect with MAX_OUT requests in flight
        mem_en = 0;
        repeat (4) cyc();
        chk("s4_req_full", imem_req, 1'b0);
        chk("s4_inflight", mq_addr.size(), MAX_OUT);
        pend_redir = 1; pend_tgt = 32'h0000_0103;
        cyc();
        mem_en = 1;
        repeat (8) cyc();
        chk("s4_first_pc", first_pc, 32'h0000_0100);

        // redirect coinciding with a pop and a response
        repeat (6) cyc();
        pend_redir = 1; pend_tgt = 32'h0000_0200;
        cyc();
        chk("s5_pop_same_cycle", out_valid, 1'b1);
        chk("s5_rsp_same_cycle", imem_rvalid, 1'b1);
        repeat (6) cyc();
        chk("s5_first_pc", first_pc, 32'h0000_0200);

        // random traffic, starting with a redirect near the top of the address space
        pend_redir = 1; pend_tgt = 32'hFFFF_FFF6;
        for (int i = 0; i < 500; i++) begin
            gnt_v   = ($urandom_range(0, 3) != 0);
            ready_v = ($urandom_range(0, 2) != 0);
            mem_en  = ($urandom_range(0, 3) != 0);
            if (i > 0 && $urandom_range(0, 29) == 0) begin
                pend_redir = 1; pend_tgt = $urandom;
            end
            cyc();
        end

        // async reset while draining
        gnt_v = 1; ready_v = 1; mem_en = 1;
        repeat (4) cyc();
        mem_en = 0;
        repeat (4) cyc();
        pend_redir = 1; pend_tgt = 32'h0000_0300;
        cyc();
        cyc();
        chk("s7_req_drain", imem_req, 1'b0);
        do_reset();
        gnt_v = 1; ready_v = 1; mem_en = 1;
        repeat (8) cyc();
        chk("s7_latency", first_ov - first_gnt, 2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MAX_OUT, 2, maximum outstanding memory requests (1..DEPTH).
REQ-003 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; reset input 1, async active-low reset.
REQ-005 SHALL have imem_req output 1, instruction-memory request valid.
REQ-006 SHALL have imem_addr output 32, word-aligned request address.
REQ-007 SHALL have imem_gnt input 1, request accepted this cycle.
REQ-008 SHALL have imem_rvalid input 1, response data valid; responses return in request order.
REQ-009 SHALL have imem_rdata input 32, response instruction word.
REQ-010 SHALL have redirect_valid input 1, branch/jump redirect from execute.
REQ-011 SHALL have redirect_pc input 32, redirect target address.
REQ-012 SHALL have out_valid output 1, instruction available to decode.
REQ-013 SHALL have out_inst output 32, instruction word.
REQ-014 SHALL have out_pc output 32, address of out_inst.
REQ-015 SHALL have out_ready input 1, decode accepts instruction.

Function
REQ-016 SHALL issue a request when imem_req=1 and imem_gnt=1 in the same cycle; fetch_pc then advances by 4 (mod 2^32).
REQ-017 SHALL assert imem_req only when fifo_count + outstanding < DEPTH and outstanding < MAX_OUT, state is RUN, and redirect_valid=0.
REQ-018 SHALL hold imem_addr stable while imem_req=1 and imem_gnt=0.
REQ-019 SHALL write each non-stale response (imem_rdata, and its issue PC from an in-order PC queue) into the FIFO on the imem_rvalid cycle.
REQ-020 SHALL present the FIFO head combinationally on out_inst/out_pc with out_valid = (fifo_count != 0); an entry pops when out_valid and out_ready.
REQ-021 SHALL support a simultaneous push and pop with fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-022 SHALL give a minimum latency of 2 cycles from grant to out_valid when memory responds the cycle after grant.
REQ-023 SHALL hold out_valid, out_inst and out_pc stable while out_valid=1 and out_ready=0.
REQ-024 SHALL implement states RUN and DRAIN.
REQ-025 On redirect_valid=1 in either state, SHALL: flush FIFO (count=0, out_valid=0 next cycle); set fetch_pc=redirect_pc; set discard = outstanding after this cycle's grant/response; go to DRAIN if discard>0, else RUN.
REQ-026 In DRAIN, SHALL drop each imem_rvalid response and decrement discard, then enter RUN when discard reaches 0; no requests issue in DRAIN.
REQ-027 SHALL treat a redirect coinciding with a pop as flush-priority, with the pop still completing.
REQ-028 SHALL treat a redirect coinciding with a response as stale and count that response in the discard calculation.
REQ-029 SHALL ignore imem_rvalid with outstanding=0; this condition is flagged by a simulation assertion.
REQ-030 SHALL force redirect_pc[1:0] to 2'b00.

Reset
REQ-031 Asserting reset, asynchronously and mid-transaction, SHALL set fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state RUN, imem_req=0, out_valid=0, out_inst=0, out_pc=0.
REQ-032 SHALL not issue the first request before the first clock edge after reset deassertion.
REQ-033 Responses arriving from requests issued before reset SHALL be the memory's responsibility and are not required to be discarded.

Structure
REQ-034 SHALL take the fetch state enum (RUN, DRAIN), XLEN=32 and the instruction width from a shared package core_pkg.
REQ-035 SHALL place the FIFO in one sub-module, fetch_fifo (DEPTH entries of {pc,inst}, push/pop/flush, count output).
REQ-036 SHALL place the PC queue for in-flight requests as a MAX_OUT-deep ring inside fetch_unit.

Verification
REQ-037 Bench SHALL cover: reset release, 1-cycle memory, out_ready=1 -> imem_addr 0,4,8,...; out_pc 0,4,8 on consecutive cycles starting 2 cycles after first grant.
REQ-038 Bench SHALL cover: out_ready=0 for 10 cycles -> fifo fills to 4, imem_req drops, out_inst/out_pc held at pc 0.
REQ-039 Bench SHALL cover: imem_gnt low 3 cycles with imem_req high -> imem_addr stable; no duplicate or skipped PCs.
REQ-040 Bench SHALL cover: redirect to 0x100 with 2 outstanding -> DRAIN for 2 responses, both dropped; next out_pc=0x100.
REQ-041 Bench SHALL cover: redirect coinciding with pop and response -> that response dropped, out_valid=0 next cycle, fetch resumes at target.
REQ-042 Bench SHALL cover: async reset asserted mid-DRAIN -> all outputs zero immediately, first imem_addr after release = RESET_PC.
